// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: writeback, debug, multicycle and clear sequencer.
// Optional RF_WSCHED_PERF_EN adds a saturating blocked-request counter.
module regfile_write_sched #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [AW-1:0]   dbg_rd,
  input  logic [XLEN-1:0] dbg_wd,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [AW-1:0]   mc_rd,
  input  logic [XLEN-1:0] mc_wd,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done,
  output logic            stall_req,
  output logic            wb_drop,
`ifdef RF_WSCHED_PERF_EN
  output logic [15:0]     perf_conflict_cnt,
`endif
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd3
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic          rr;

  logic idle;
  logic clear;
  logic done;
  logic g_dbg;
  logic g_mc;

  assign idle  = (state == S_IDLE);
  assign clear = (state == S_CLEAR);
  assign done  = (state == S_DONE);

  // rr=0 favours debug, rr=1 favours multicycle
  assign g_dbg = idle & ~wb_we & dbg_valid
               & (~mc_valid | ~rr);
  assign g_mc  = idle & ~wb_we & mc_valid
               & (~dbg_valid | rr);

  assign dbg_ready = g_dbg;
  assign mc_ready  = g_mc;
  assign clr_busy  = clear;
  assign stall_req = clear;
  assign clr_done  = done;
  assign wb_drop   = clear & wb_we;

  always_comb begin
    rf_we  = 1'b0;
    rf_a3  = '0;
    rf_wd3 = '0;
    unique case (1'b1)
      clear: begin
        rf_we = 1'b1;
        rf_a3 = cnt;
      end
      idle & wb_we: begin
        rf_we  = (wb_rd != '0);
        rf_a3  = wb_rd;
        rf_wd3 = wb_wd;
      end
      g_dbg: begin
        rf_we  = (dbg_rd != '0);
        rf_a3  = dbg_rd;
        rf_wd3 = dbg_wd;
      end
      g_mc: begin
        rf_we  = (mc_rd != '0);
        rf_a3  = mc_rd;
        rf_wd3 = mc_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= CNT_FIRST;
      rr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_req)
            state <= S_CLEAR;
          if (g_dbg)
            rr <= 1'b1;
          else if (g_mc)
            rr <= 1'b0;
        end
        S_CLEAR: begin
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            cnt   <= CNT_FIRST;
          end else begin
            cnt <= cnt + CNT_FIRST;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RF_WSCHED_PERF_EN
  logic blocked;

  assign blocked = (dbg_valid | mc_valid)
                 & ~(g_dbg | g_mc);

  always_ff @(posedge clk) begin
    if (rst)
      perf_conflict_cnt <= '0;
    else if (blocked && perf_conflict_cnt != 16'hFFFF)
      perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: scenario tasks plus a write scoreboard.
// Expected rf writes are queued at stimulus time and popped by a monitor.
module tb_regfile_write_sched;

  localparam int AW   = 5;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            dbg_valid;
  logic            dbg_ready;
  logic [AW-1:0]   dbg_rd;
  logic [XLEN-1:0] dbg_wd;
  logic            mc_valid;
  logic            mc_ready;
  logic [AW-1:0]   mc_rd;
  logic [XLEN-1:0] mc_wd;
  logic            clr_req;
  logic            clr_busy;
  logic            clr_done;
  logic            stall_req;
  logic            wb_drop;
  logic            rf_we;
  logic [AW-1:0]   rf_a3;
  logic [XLEN-1:0] rf_wd3;
`ifdef RF_WSCHED_PERF_EN
  logic [15:0]     perf_conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [AW+XLEN-1:0] exp_q[$];

  regfile_write_sched #(.DEPTH(32), .AW(AW), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_wd     (wb_wd),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_rd    (dbg_rd),
    .dbg_wd    (dbg_wd),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_rd     (mc_rd),
    .mc_wd     (mc_wd),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .stall_req (stall_req),
    .wb_drop   (wb_drop),
`ifdef RF_WSCHED_PERF_EN
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every rf write must match the next queued entry
  always @(negedge clk) begin
    #2;
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got a3=%0d wd=%h, required no write",
                 rf_a3, rf_wd3);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        if ({rf_a3, rf_wd3} !== e) begin
          failures++;
          $display("FAIL sb_write: got a3=%0d wd=%h, required a3=%0d wd=%h",
                   rf_a3, rf_wd3, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    wb_we = 0; wb_rd = '0; wb_wd = '0;
    dbg_valid = 0; dbg_rd = '0; dbg_wd = '0;
    mc_valid = 0; mc_rd = '0; mc_wd = '0;
    clr_req = 0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({rf_we, rf_a3, rf_wd3, dbg_ready, mc_ready, clr_busy,
         clr_done, stall_req, wb_drop} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b a3=%0d wd=%h rdy=%b%b busy=%b done=%b stall=%b drop=%b, required all 0",
               rf_we, rf_a3, rf_wd3, dbg_ready, mc_ready, clr_busy,
               clr_done, stall_req, wb_drop);
    end
  endtask

  task automatic test_wb();
    @(negedge clk);
    wb_we = 1; wb_rd = 5; wb_wd = 32'hDEADBEEF;
    push(5, 32'hDEADBEEF);
    #1;
    checks++;
    if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL wb_write: got we=%b a3=%0d wd=%h, required 1/5/deadbeef",
               rf_we, rf_a3, rf_wd3);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wb_vs_dbg();
    @(negedge clk);
    wb_we = 1; wb_rd = 3; wb_wd = 32'hA5A5A5A5;
    dbg_valid = 1; dbg_rd = 7; dbg_wd = 32'h11;
    push(3, 32'hA5A5A5A5);
    #1;
    checks++;
    if (dbg_ready !== 1'b0 || rf_a3 !== 5'd3) begin
      failures++;
      $display("FAIL wb_prio: got dbg_ready=%b a3=%0d, required 0/3",
               dbg_ready, rf_a3);
    end
    @(negedge clk);
    wb_we = 0;
    push(7, 32'h11);
    #1;
    checks++;
    if ({dbg_ready, rf_a3, rf_wd3} !== {1'b1, 5'd7, 32'h11}) begin
      failures++;
      $display("FAIL dbg_grant: got rdy=%b a3=%0d wd=%h, required 1/7/11",
               dbg_ready, rf_a3, rf_wd3);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    dbg_valid = 1; dbg_rd = 9;  dbg_wd = 32'hD0;
    mc_valid  = 1; mc_rd  = 10; mc_wd  = 32'hC0;
    for (int i = 0; i < 4; i++) begin
      logic exp_d;
      exp_d = (i % 2 == 0);
      if (exp_d) push(9, 32'hD0);
      else       push(10, 32'hC0);
      #1;
      checks++;
      if (dbg_ready !== exp_d || mc_ready !== !exp_d) begin
        failures++;
        $display("FAIL rr_grant%0d: got dbg=%b mc=%b, required dbg=%b mc=%b",
                 i, dbg_ready, mc_ready, exp_d, !exp_d);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    @(negedge clk);
    mc_valid = 1; mc_rd = 0; mc_wd = 32'h55;
    #1;
    checks++;
    if (mc_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL x0_mc: got ready=%b we=%b, required 1/0",
               mc_ready, rf_we);
    end
    @(negedge clk);
    idle_inputs();
    wb_we = 1; wb_rd = 0; wb_wd = 32'h77;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL x0_wb: got we=%b, required 0", rf_we);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cycles;
    busy_cycles = 0;
    do_reset();
    @(negedge clk);
    clr_req = 1;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_pre: got busy=%b, required 0", clr_busy);
    end
    for (int i = 1; i <= 31; i++) push(AW'(i), '0);
    @(negedge clk);
    clr_req = 0;
    for (int i = 1; i <= 31; i++) begin
      wb_we     = (i == 15);
      wb_rd     = 4;
      wb_wd     = 32'hBAD;
      dbg_valid = (i == 20);
      dbg_rd    = 2;
      #1;
      if (clr_busy === 1'b1 && stall_req === 1'b1) busy_cycles++;
      checks++;
      if (rf_a3 !== AW'(i) || rf_wd3 !== '0 || rf_we !== 1'b1) begin
        failures++;
        $display("FAIL clr_write%0d: got we=%b a3=%0d wd=%h, required 1/%0d/0",
                 i, rf_we, rf_a3, rf_wd3, i);
      end
      if (i == 15) begin
        checks++;
        if (wb_drop !== 1'b1) begin
          failures++;
          $display("FAIL wb_drop: got %b, required 1", wb_drop);
        end
      end
      if (i == 20) begin
        checks++;
        if (dbg_ready !== 1'b0) begin
          failures++;
          $display("FAIL clr_dbg_block: got %b, required 0", dbg_ready);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (busy_cycles != 31) begin
      failures++;
      $display("FAIL clr_len: got %0d busy cycles, required 31", busy_cycles);
    end
    #1;
    checks++;
    if ({clr_done, clr_busy, stall_req, rf_we} !== 4'b1000) begin
      failures++;
      $display("FAIL clr_done: got done=%b busy=%b stall=%b we=%b, required 1/0/0/0",
               clr_done, clr_busy, stall_req, rf_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_idle: got done=%b busy=%b, required 0/0",
               clr_done, clr_busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    @(negedge clk);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    for (int i = 1; i <= 10; i++) begin
      push(AW'(i), '0);
      if (i == 10) rst = 1;
      #1;
      if (i == 10) begin
        checks++;
        if (rf_a3 !== 5'd10) begin
          failures++;
          $display("FAIL mid_a3: got %0d, required 10", rf_a3);
        end
      end
      @(negedge clk);
    end
    rst = 0;
    #1;
    checks++;
    if ({clr_busy, clr_done, stall_req, rf_we} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_abort: got busy=%b done=%b stall=%b we=%b, required 0",
               clr_busy, clr_done, stall_req, rf_we);
    end
    @(negedge clk);
    clr_req = 1;
    #1;
    checks++;
    if (clr_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_nodone: got %b, required 0", clr_done);
    end
    @(negedge clk);
    clr_req = 0;
    push(1, '0);
    #1;
    checks++;
    if (rf_a3 !== 5'd1 || clr_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart: got a3=%0d busy=%b, required 1/1",
               rf_a3, clr_busy);
    end
    @(negedge clk);
    push(2, '0);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

`ifdef RF_WSCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    @(negedge clk);
    dbg_valid = 1; dbg_rd = 12; dbg_wd = 32'h99;
    wb_we = 1; wb_rd = 6; wb_wd = 32'h66;
    for (int i = 0; i < 3; i++) begin
      push(6, 32'h66);
      @(negedge clk);
    end
    wb_we = 0;
    push(12, 32'h99);
    #1;
    checks++;
    if (perf_conflict_cnt !== 16'd3 || dbg_ready !== 1'b1) begin
      failures++;
      $display("FAIL perf_cnt: got cnt=%0d rdy=%b, required 3/1",
               perf_conflict_cnt, dbg_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (perf_conflict_cnt !== 16'd3) begin
      failures++;
      $display("FAIL perf_hold: got %0d, required 3", perf_conflict_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_wb();
    test_wb_vs_dbg();
    test_back_to_back();
    test_x0();
    test_clear();
    test_reset_mid_clear();
`ifdef RF_WSCHED_PERF_EN
    test_perf();
`endif
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending writes, required 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
